// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package ifb_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } ifb_entry_t;

endpackage

// File: rtl/inst_prefetch_buf_if.sv
// ROM-side and core-side signals of the prefetch buffer; master is the buffer itself.
interface inst_prefetch_buf_if import ifb_pkg::*; ();

  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_ce_o;
  logic [DATA_W-1:0] rom_data_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;

  modport master (
    output rom_addr_o, rom_ce_o, inst_valid_o, inst_o, inst_pc_o,
    input  rom_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );

  modport slave (
    input  rom_addr_o, rom_ce_o, inst_valid_o, inst_o, inst_pc_o,
    output rom_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );

endinterface

// File: rtl/ifb_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush; head reads as zero when empty.
module ifb_fifo import ifb_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  ifb_entry_t wr_entry,
  output logic       full,
  output logic       empty,
  output ifb_entry_t head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  ifb_entry_t      mem_q [DEPTH];

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: stale slots are masked by the count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch buffer: owns the fetch PC, reads inst_rom, queues {pc, inst} for the core.
// Optional performance counters are built when IFB_PERF_EN is defined.
module inst_prefetch_buf import ifb_pkg::*; #(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  inst_prefetch_buf_if.master bus
`ifdef IFB_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt_o,
  output logic [31:0]         perf_flush_cnt_o
`endif
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              rom_ce_q;
  logic              push, pop, full, empty;
  ifb_entry_t        head, wr_entry;

  assign pop  = bus.inst_valid_o & bus.inst_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = rom_ce_q & ~bus.redirect_i & (~full | pop);

  assign wr_entry = '{pc: fetch_pc_q, inst: bus.rom_data_i};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_i) begin
      fetch_pc_d = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(INST_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rom_ce_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rom_ce_q   <= 1'b1;
    end
  end

  ifb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (bus.redirect_i),
    .wr_entry (wr_entry),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  assign bus.rom_addr_o   = fetch_pc_q;
  assign bus.rom_ce_o     = rom_ce_q;
  assign bus.inst_valid_o = ~empty;
  assign bus.inst_o       = head.inst;
  assign bus.inst_pc_o    = head.pc;

`ifdef IFB_PERF_EN
  logic [31:0] perf_fetch_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (push)                   perf_fetch_q <= perf_fetch_q + 32'd1;
      if (bus.redirect_i && !empty) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
